// File: rtl/seed_expander_pkg.sv
// Package for the seed expander and the samplers that share its lane conventions.
// Holds the byte counts of the seed and of the squeezed output split, the lane
// geometry of the sponge word interface, the controller state encoding, and the
// byte <-> lane ordering helper.
//
// Byte/lane convention:
//   - Byte arrays (seed, rho, rhoprime, key) are stored big-endian: byte 0 sits
//     in the most-significant byte of the vector.
//   - Sponge lanes are Keccak little-endian: the first byte of a lane sits in
//     bits [7:0].
//   Converting one into the other is a byte swap of each 8-byte chunk.
package seed_expander_pkg;

  localparam int SEED_BYTES = 32;
  localparam int OUT_BYTES  = 128;
  localparam int RHO_BYTES  = 32;
  localparam int RHOP_BYTES = 64;
  localparam int KEY_BYTES  = 32;

  localparam int W          = 64;
  localparam int LANE_BYTES = W / 8;
  localparam int SEED_LANES = SEED_BYTES / LANE_BYTES;
  localparam int OUT_LANES  = OUT_BYTES / LANE_BYTES;

  // One counter serves both phases, so it is sized for the longer one.
  localparam int CNT_W = $clog2(OUT_LANES);

  typedef logic [W-1:0] lane_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ABSORB  = 2'd1,
    ST_SQUEEZE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Big-endian 8-byte chunk <-> little-endian lane. The mapping is its own
  // inverse, so the same function serves both directions.
  function automatic lane_t swap_lane_bytes(input lane_t x);
    lane_t y;
    for (int i = 0; i < LANE_BYTES; i++) begin
      y[8*i +: 8] = x[W-8-8*i +: 8];
    end
    return y;
  endfunction

endpackage

// File: rtl/seed_expander_if.sv
// Word interface between the seed expander and the external SHAKE256 sponge core.
//   absorb_data  : lane pushed into the sponge (Keccak little-endian byte order)
//   absorb_valid : absorb_data valid
//   absorb_last  : final message lane; the core appends SHAKE padding after it
//   absorb_ready : core accepts a lane when valid & ready
//   sq_data      : squeezed lane from the core
//   sq_valid     : sq_data valid
//   sq_ready     : expander accepts a squeezed lane when valid & ready
// Modports: master = seed expander side, slave = sponge core side.
interface seed_expander_if;
  import seed_expander_pkg::*;

  lane_t absorb_data;
  logic  absorb_valid;
  logic  absorb_last;
  logic  absorb_ready;
  lane_t sq_data;
  logic  sq_valid;
  logic  sq_ready;

  modport master (
    output absorb_data, absorb_valid, absorb_last, sq_ready,
    input  absorb_ready, sq_data, sq_valid
  );

  modport slave (
    input  absorb_data, absorb_valid, absorb_last, sq_ready,
    output absorb_ready, sq_data, sq_valid
  );

endinterface

// File: rtl/seed_expander_lane_packer.sv
// Combinational byte-order converter between big-endian byte chunks and
// little-endian sponge lanes.
//   chunk_in  : 8 bytes, first byte at MSB (next seed chunk)
//   lane_out  : same bytes as a sponge lane, first byte in bits [7:0]
//   lane_in   : lane squeezed from the sponge, first byte in bits [7:0]
//   chunk_out : same bytes as a big-endian chunk, first byte at MSB
module seed_expander_lane_packer
  import seed_expander_pkg::*;
(
  input  lane_t chunk_in,
  output lane_t lane_out,
  input  lane_t lane_in,
  output lane_t chunk_out
);

  assign lane_out  = swap_lane_bytes(chunk_in);
  assign chunk_out = swap_lane_bytes(lane_in);

endmodule

// File: rtl/seed_expander.sv
// Dilithium keygen seed expander: H(zeta) -> rho || rhoprime || key.
// Feeds the 32-byte seed into an external SHAKE256 sponge as four lanes, then
// collects sixteen squeezed lanes (128 bytes) and publishes them split 32/64/32.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle request, seed sampled in the same cycle (IDLE only)
//   seed       : zeta, byte 0 at MSB
//   busy       : high from the cycle after start until done
//   done       : one-cycle pulse; rho/rhoprime/key valid from this cycle on
//   sponge     : lane handshake interface towards the sponge core
//   rho        : squeezed bytes 0..31, byte 0 at MSB
//   rhoprime   : squeezed bytes 32..95, byte 32 at MSB
//   key        : squeezed bytes 96..127, byte 96 at MSB
module seed_expander
  import seed_expander_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [SEED_BYTES*8-1:0] seed,
  output logic                    busy,
  output logic                    done,
  seed_expander_if.master         sponge,
  output logic [RHO_BYTES*8-1:0]  rho,
  output logic [RHOP_BYTES*8-1:0] rhoprime,
  output logic [KEY_BYTES*8-1:0]  key
);

  state_t                   state, state_next;
  logic [CNT_W-1:0]         lane_cnt;
  logic [SEED_BYTES*8-1:0]  seed_sr;
  logic [OUT_BYTES*8-1:0]   shadow, shadow_next;

  lane_t absorb_lane;
  lane_t sq_chunk;

  logic absorb_fire, sq_fire;
  logic absorb_is_last, sq_is_last;

  logic  absorb_valid_c, absorb_last_c, sq_ready_c;
  lane_t absorb_data_c;

  // The seed shift register always presents the next unsent chunk at its top.
  seed_expander_lane_packer u_packer (
    .chunk_in  (seed_sr[SEED_BYTES*8-1 -: W]),
    .lane_out  (absorb_lane),
    .lane_in   (sponge.sq_data),
    .chunk_out (sq_chunk)
  );

  assign absorb_fire    = (state == ST_ABSORB)  && sponge.absorb_ready;
  assign sq_fire        = (state == ST_SQUEEZE) && sponge.sq_valid;
  assign absorb_is_last = (lane_cnt == CNT_W'(SEED_LANES - 1));
  assign sq_is_last     = (lane_cnt == CNT_W'(OUT_LANES - 1));

  // Squeezed lanes enter at the bottom, so after the last lane the first
  // squeezed byte has reached the MSB of the shadow.
  assign shadow_next = {shadow[OUT_BYTES*8-W-1:0], sq_chunk};

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    busy           = 1'b0;
    done           = 1'b0;
    absorb_valid_c = 1'b0;
    absorb_last_c  = 1'b0;
    absorb_data_c  = '0;
    sq_ready_c     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) state_next = ST_ABSORB;
      end
      ST_ABSORB: begin
        busy           = 1'b1;
        absorb_valid_c = 1'b1;
        absorb_data_c  = absorb_lane;
        absorb_last_c  = absorb_is_last;
        if (absorb_fire && absorb_is_last) state_next = ST_SQUEEZE;
      end
      ST_SQUEEZE: begin
        busy       = 1'b1;
        sq_ready_c = 1'b1;
        if (sq_fire && sq_is_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign sponge.absorb_valid = absorb_valid_c;
  assign sponge.absorb_last  = absorb_last_c;
  assign sponge.absorb_data  = absorb_data_c;
  assign sponge.sq_ready     = sq_ready_c;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the data registers are reset too, not just the control: a reset in
  // the middle of a run must leave no seed material or partial output visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt <= '0;
      seed_sr  <= '0;
      shadow   <= '0;
      rho      <= '0;
      rhoprime <= '0;
      key      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            seed_sr  <= seed;
            lane_cnt <= '0;
          end
        end
        ST_ABSORB: begin
          if (absorb_fire) begin
            seed_sr  <= seed_sr << W;
            lane_cnt <= absorb_is_last ? '0 : lane_cnt + CNT_W'(1);
          end
        end
        ST_SQUEEZE: begin
          if (sq_fire) begin
            shadow   <= shadow_next;
            lane_cnt <= sq_is_last ? '0 : lane_cnt + CNT_W'(1);
            // Published only on the final lane, so the outputs change exactly
            // as done rises and never show a partially filled block.
            if (sq_is_last) {rho, rhoprime, key} <= shadow_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
